// File: rtl/tcon_pkg.sv
// Shared types for the tcon select arbiter.
// - state_e   : arbiter FSM states
// - req_id_e  : requester identity, encoded the same way as the mux select
// - DefaultDw : default beat width, one bit per tcon mux lane
package tcon_pkg;

  localparam int unsigned DefaultDw = 8;
  localparam int unsigned CntW      = 4;
  localparam int unsigned TurnW     = 3;

  typedef enum logic [1:0] {
    StIdle,
    StGntA,
    StGntB,
    StTurn
  } state_e;

  // Matches sel: 1 picks lane group A, 0 picks lane group B.
  typedef enum logic {
    ReqB = 1'b0,
    ReqA = 1'b1
  } req_id_e;

endpackage

// File: rtl/tcon_out_reg.sv
// Single-entry registered output stage with a valid/ready handshake.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   load_i            : capture data_i/last_i this cycle
//   data_i, last_i    : beat to capture
//   ready_i           : sink accepts the held beat
//   valid_o           : a beat is held
//   data_o, last_o    : the held beat
// The caller only loads when the slot is empty or draining, so a load never
// overwrites an unconsumed beat.
module tcon_out_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q;
  logic          last_q;

  always_comb begin
    valid_d = valid_q;
    if (load_i) begin
      valid_d = 1'b1;  // also covers simultaneous drain and load
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q <= data_i;
        last_q <= last_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/tcon_arbiter.sv
// Two-requester burst arbiter owning the select of the 8-lane tcon 2:1 mux.
// Round-robin between A and B, caps bursts at MAX_BURST beats, and inserts
// TURN dead cycles between grants. The forwarded beat is registered.
// Ports:
//   clk_i, rst_i                         : clock, synchronous active-high reset
//   a_req_i/a_data_i/a_last_i, a_gnt_o   : requester A (primary lanes)
//   b_req_i/b_data_i/b_last_i, b_gnt_o   : requester B (bypass lanes)
//   sel_o                                : mux select, 1 = A, 0 = B
//   o_valid_o/o_data_o/o_last_o, o_ready_i : registered beat toward the sink
//   trunc_o                              : pulse after a burst cut at MAX_BURST
//   busy_o                               : arbiter not idle
module tcon_arbiter
  import tcon_pkg::*;
#(
  parameter int unsigned DW        = DefaultDw,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TURN      = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          a_req_i,
  input  logic [DW-1:0] a_data_i,
  input  logic          a_last_i,
  output logic          a_gnt_o,
  input  logic          b_req_i,
  input  logic [DW-1:0] b_data_i,
  input  logic          b_last_i,
  output logic          b_gnt_o,
  output logic          sel_o,
  output logic          o_valid_o,
  output logic [DW-1:0] o_data_o,
  output logic          o_last_o,
  input  logic          o_ready_i,
  output logic          trunc_o,
  output logic          busy_o
);

  localparam logic [CntW-1:0]  CapCnt   = CntW'(MAX_BURST - 1);
  localparam logic [TurnW-1:0] TurnInit = TurnW'(TURN - 1);

  state_e            state_q;
  req_id_e           last_owner_q;
  logic              sel_q;
  logic [CntW-1:0]   cnt_q;
  logic [TurnW-1:0]  turn_q;
  logic              trunc_q;

  logic              in_gnt, x_req, x_last, x_gnt, accept, at_cap, beat_last;
  logic [DW-1:0]     x_data;

  // sel_q always names the current owner while in a grant state.
  always_comb begin
    in_gnt    = (state_q == StGntA) || (state_q == StGntB);
    x_req     = sel_q ? a_req_i  : b_req_i;
    x_last    = sel_q ? a_last_i : b_last_i;
    x_data    = sel_q ? a_data_i : b_data_i;
    x_gnt     = in_gnt & (!o_valid_o | o_ready_i);
    accept    = x_req & x_gnt;
    at_cap    = (cnt_q == CapCnt);
    beat_last = x_last | at_cap;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      last_owner_q <= ReqB;  // A wins the first tie
      sel_q        <= 1'b0;
      cnt_q        <= '0;
      turn_q       <= '0;
      trunc_q      <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (a_req_i && (!b_req_i || last_owner_q == ReqB)) begin
            state_q <= StGntA;
            sel_q   <= 1'b1;
          end else if (b_req_i) begin
            state_q <= StGntB;
            sel_q   <= 1'b0;
          end
        end
        StGntA, StGntB: begin
          if (!x_req || (accept && beat_last)) begin
            state_q      <= StTurn;
            last_owner_q <= req_id_e'(sel_q);
            cnt_q        <= '0;
            turn_q       <= TurnInit;
            trunc_q      <= accept && at_cap && !x_last;
          end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StTurn: begin
          if (turn_q == '0) begin
            state_q <= StIdle;
          end else begin
            turn_q <= turn_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  tcon_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (accept),
    .data_i  (x_data),
    .last_i  (beat_last),
    .ready_i (o_ready_i),
    .valid_o (o_valid_o),
    .data_o  (o_data_o),
    .last_o  (o_last_o)
  );

  assign a_gnt_o = x_gnt & sel_q;
  assign b_gnt_o = x_gnt & !sel_q;
  assign sel_o   = sel_q;
  assign trunc_o = trunc_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_tcon_arbiter.sv
// Bench for tcon_arbiter: directed bursts with literal expectations, then
// randomized requesters checked every cycle against a behavioural model.
module tb_tcon_arbiter;

  localparam int unsigned DW        = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned TURN      = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_req = 1'b0, b_req = 1'b0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_last = 1'b0, b_last = 1'b0;
  logic          o_ready = 1'b1;
  logic          a_gnt, b_gnt, sel, o_valid, o_last, trunc, busy;
  logic [DW-1:0] o_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tcon_arbiter #(
    .DW        (DW),
    .MAX_BURST (MAX_BURST),
    .TURN      (TURN)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .a_req_i   (a_req),
    .a_data_i  (a_data),
    .a_last_i  (a_last),
    .a_gnt_o   (a_gnt),
    .b_req_i   (b_req),
    .b_data_i  (b_data),
    .b_last_i  (b_last),
    .b_gnt_o   (b_gnt),
    .sel_o     (sel),
    .o_valid_o (o_valid),
    .o_data_o  (o_data),
    .o_last_o  (o_last),
    .o_ready_i (o_ready),
    .trunc_o   (trunc),
    .busy_o    (busy)
  );

  // Behavioural model: owner -1 = none, 1 = A, 0 = B. m_turn counts remaining
  // dead cycles; the arbiter is idle when there is no owner and no gap left.
  int          m_owner = -1;
  int          m_beats = 0;
  int          m_turn  = 0;
  int          m_last_owner = 0;
  logic        m_sel   = 1'b0;
  logic        m_trunc = 1'b0;
  logic [8:0]  m_out[$];  // {last, data}
  bit          m_known = 1'b0;
  bit          m_acc[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic       req [2];
    logic       lst [2];
    logic [7:0] dat [2];
    logic       g, acc, cap;
    m_acc[0] = 1'b0;
    m_acc[1] = 1'b0;
    if (rst) begin
      m_owner = -1; m_beats = 0; m_turn = 0; m_last_owner = 0;
      m_sel = 1'b0; m_trunc = 1'b0; m_out.delete(); m_known = 1'b1;
      return;
    end
    req[1] = a_req; lst[1] = a_last; dat[1] = a_data;
    req[0] = b_req; lst[0] = b_last; dat[0] = b_data;
    g   = (m_owner >= 0) && (m_out.size() == 0 || o_ready);
    acc = (m_owner >= 0) && g && req[m_owner];
    cap = (m_beats == MAX_BURST - 1);
    m_trunc = 1'b0;
    if (o_ready && m_out.size() != 0) m_out.delete(0);
    if (acc) begin
      m_acc[m_owner] = 1'b1;
      m_out.push_back({lst[m_owner] | cap, dat[m_owner]});
      m_trunc = cap && !lst[m_owner];
    end
    if (m_owner >= 0) begin
      if (!req[m_owner] || (acc && (lst[m_owner] || cap))) begin
        m_last_owner = m_owner;
        m_owner = -1;
        m_beats = 0;
        m_turn  = TURN;
      end else if (acc) begin
        m_beats++;
      end
    end else if (m_turn > 0) begin
      m_turn--;
    end else if (req[1] && (!req[0] || m_last_owner == 0)) begin
      m_owner = 1; m_sel = 1'b1;
    end else if (req[0]) begin
      m_owner = 0; m_sel = 1'b0;
    end
  endtask

  // Called at posedge+1 with inputs set; compares at posedge+2, then advances.
  task automatic cycle();
    logic g;
    #1;
    if (m_known) begin
      g = (m_owner >= 0) && (m_out.size() == 0 || o_ready);
      chk("sel", sel, m_sel);
      chk("busy", busy, (m_owner >= 0 || m_turn > 0));
      chk("a_gnt", a_gnt, g && m_owner == 1);
      chk("b_gnt", b_gnt, g && m_owner == 0);
      chk("o_valid", o_valid, m_out.size() != 0);
      chk("trunc", trunc, m_trunc);
      if (m_out.size() != 0) begin
        chk("o_data", o_data, m_out[0][7:0]);
        chk("o_last", o_last, m_out[0][8]);
      end
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic req, input logic [7:0] d, input logic l);
    a_req = req; a_data = d; a_last = l;
  endtask

  task automatic drive_b(input logic req, input logic [7:0] d, input logic l);
    b_req = req; b_data = d; b_last = l;
  endtask

  // Random requester state: 1 = A, 0 = B.
  bit         r_active [2];
  int         r_len    [2];
  int         r_idx    [2];
  logic [7:0] r_dat    [2];

  initial begin
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    // Reset values.
    chk("rst_sel", sel, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_data", o_data, 8'h00);
    chk("rst_last", o_last, 1'b0);
    chk("rst_trunc", trunc, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // A single 3-beat burst.
    o_ready = 1'b1;
    drive_a(1'b1, 8'h11, 1'b0);
    cycle();
    chk("a3_sel", sel, 1'b1);
    chk("a3_busy", busy, 1'b1);
    chk("a3_nov", o_valid, 1'b0);
    cycle();
    chk("a3_d1", o_data, 8'h11);
    chk("a3_v1", o_valid, 1'b1);
    chk("a3_l1", o_last, 1'b0);
    drive_a(1'b1, 8'h22, 1'b0);
    cycle();
    chk("a3_d2", o_data, 8'h22);
    drive_a(1'b1, 8'h33, 1'b1);
    cycle();
    chk("a3_d3", o_data, 8'h33);
    chk("a3_l3", o_last, 1'b1);
    chk("a3_tr", trunc, 1'b0);
    chk("a3_turn", busy, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0);
    cycle();
    chk("a3_idle", busy, 1'b0);
    chk("a3_drain", o_valid, 1'b0);
    chk("a3_selhold", sel, 1'b1);

    // Burst without last gets cut after MAX_BURST beats.
    drive_a(1'b1, 8'h40, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 8'(8'h40 + i), 1'b0);
      cycle();
    end
    chk("cap_data", o_data, 8'h43);
    chk("cap_last", o_last, 1'b1);
    chk("cap_trunc", trunc, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0);
    drive_b(1'b1, 8'h55, 1'b0);
    cycle();
    chk("cap_pulse", trunc, 1'b0);
    chk("cap_idle", busy, 1'b0);
    cycle();
    chk("b_sel", sel, 1'b0);
    o_ready = 1'b0;
    cycle();
    chk("b_valid", o_valid, 1'b1);
    chk("b_data", o_data, 8'h55);
    // Reset mid-grant with a pending beat.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    o_ready = 1'b1;
    chk("mid_valid", o_valid, 1'b0);
    chk("mid_sel", sel, 1'b0);
    chk("mid_busy", busy, 1'b0);
    drive_a(1'b1, 8'h66, 1'b1);
    drive_b(1'b1, 8'h77, 1'b1);
    cycle();
    chk("tie_a", sel, 1'b1);

    // Randomized phase.
    for (int r = 0; r < 2; r++) begin
      r_active[r] = 1'b0; r_len[r] = 0; r_idx[r] = 0; r_dat[r] = '0;
    end
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 599) == 0);
      o_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 2; r++) begin
        if (r_active[r] && $urandom_range(0, 39) == 0) begin
          r_active[r] = 1'b0;  // abandon the rest of the burst
        end else if (!r_active[r] && $urandom_range(0, 2) == 0) begin
          r_active[r] = 1'b1;
          r_len[r]    = $urandom_range(1, 7);
          r_idx[r]    = 0;
          r_dat[r]    = 8'($urandom);
        end
      end
      drive_a(r_active[1], r_dat[1], r_idx[1] == r_len[1] - 1);
      drive_b(r_active[0], r_dat[0], r_idx[0] == r_len[0] - 1);
      cycle();
      for (int r = 0; r < 2; r++) begin
        if (m_acc[r]) begin
          r_idx[r]++;
          r_dat[r] = 8'($urandom);
          if (r_idx[r] == r_len[r]) r_active[r] = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tcon_arbiter.md
# tcon_arbiter

Two-requester burst arbiter that owns the select line of the 8-lane `tcon` 2:1 bus multiplexer. It decides which source bus (A: primary lanes, B: bypass lanes) drives the shared output. It also sequences bursts with round-robin fairness, a burst-length cap and a bus turnaround gap. The beat it forwards is registered, with a valid/ready handshake toward the sink.

## Interface
- `DW`, 8: data width per source; matches the 8 mux lanes.
- `MAX_BURST`, 4: maximum beats per grant, legal range 1..15. Reaching it forces release.
- `TURN`, 1: dead cycles between releasing one grant and arbitrating the next, legal range 1..7.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_req` in 1: requester A has a valid beat; held high for the whole burst.
- `a_data` in DW: requester A beat data.
- `a_last` in 1: the current A beat is the final beat of its burst.
- `a_gnt` out 1: A beat accepted this cycle when `a_req & a_gnt`.
- `b_req`, `b_data`, `b_last`, `b_gnt`: same as the A signals, for requester B.
- `sel` out 1: mux select (the `tcon` `i` input). 1 selects A, 0 selects B.
- `o_valid` out 1: the output register holds a beat.
- `o_data` out DW: the registered beat.
- `o_last` out 1: the registered beat ends a burst, either a requester `last` or a forced cap.
- `o_ready` in 1: sink accepts a beat when `o_valid & o_ready`.
- `trunc` out 1: one-cycle pulse when a grant is force-released at `MAX_BURST` without `last`.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, GNT_A, GNT_B, TURN.
- IDLE, arbitration:
  - A only requesting → GNT_A.
  - B only requesting → GNT_B.
  - Both requesting → grant the requester that is not `last_owner`.
  - Neither requesting → stay in IDLE.
- `sel` loads on entry to GNT_A (1) or GNT_B (0). It holds through TURN and IDLE and changes only on grant entry.
- In GNT_X, `x_gnt = !o_valid | o_ready`. The other requester's grant is 0.
- Beat accepted when `x_req & x_gnt`:
  - output register loads data;
  - `o_last = x_last | (cnt == MAX_BURST-1)`;
  - `cnt` increments.
- Release from GNT_X to TURN on any of:
  - an accepted beat with `x_last`;
  - an accepted beat with `cnt == MAX_BURST-1`; `trunc` pulses if `x_last` was 0;
  - `x_req` low in any cycle (abandoned burst).
- On release: `last_owner` ← X, `cnt` ← 0, turn counter ← `TURN-1`. TURN decrements to 0, then goes to IDLE.
- Output register:
  - `o_valid` sets on an accepted beat;
  - `o_valid` clears on `o_ready` with no new beat;
  - a simultaneous drain and load keeps `o_valid` = 1 with the new data.
- `cnt` width: 4 bits. No wrap is possible because release occurs at `MAX_BURST`.

## Timing
- Request to grant: a request seen in IDLE at cycle n gives state GNT at n+1 and earliest `x_gnt` at n+1.
- Accept to output: a beat accepted at cycle n is on `o_data`/`o_valid` at n+1. Full throughput is 1 beat/cycle while `o_ready` is held high.
- Release to re-arbitration: release at cycle n enters TURN at n+1. IDLE is reached at n+1+TURN, and the next grant comes one cycle after that.
- Reset values: state IDLE, `sel` 0, `o_valid` 0, `o_data` 0, `o_last` 0, `trunc` 0, `busy` 0, `a_gnt`/`b_gnt` 0, `cnt` 0, `last_owner` B (so A wins the first tie).
- Reset mid-burst: all state returns to the reset values on the next edge. A pending output beat is dropped.
- Backpressure: `o_ready` low holds `o_data` stable and drives `x_gnt` to 0. The grant is not released while stalled, provided `x_req` stays high.

## Structure
- Shared package `tcon_pkg`: the state enum (IDLE, GNT_A, GNT_B, TURN), the requester ID enum (A=1, B=0, equal to the `sel` encoding), and the `DW` default.
- One sub-module, `tcon_out_reg`: the single-entry registered output stage with valid/ready, data and last.
- Top-level integration: `sel` drives `tcon.i`. A and B data feed the two mux lane groups. This arbiter forwards the selected beat.

## Test plan
- Single A burst of 3 beats (`last` on the 3rd), `o_ready` = 1 → `sel` = 1, `o_data` sequence 3 beats at 1/cycle, `o_last` on the 3rd, `trunc` = 0, IDLE after TURN+1 cycles.
- A and B both request from reset, `MAX_BURST` = 4, each sends 2-beat bursts → grant order A, B, A, B. The gap between the last beat of one grant and the first beat of the next is `TURN`+2 cycles.
- A 6-beat burst with no `last` until beat 6, `MAX_BURST` = 4 → release after beat 4 with `o_last` = 1 and a `trunc` pulse. B, if requesting, is granted next. A re-arbitrates later for the remaining 2 beats.
- `o_ready` low for 3 cycles mid-burst → `o_data` stable, `a_gnt` = 0, state stays GNT_A, and the burst completes after `o_ready` returns.
- The owner drops `req` after 1 beat → release to TURN with no `trunc`, and the other requester is granted.
- `rst` asserted during GNT_B with `o_valid` = 1 → next cycle `o_valid` = 0, `sel` = 0, state IDLE, and a following tie is won by A.
